// File: rtl/mp_pkg.sv
// rtl/mp_pkg.sv - shared encodings and sizing helper for the multi-precision add/sub block
// Holds the operation mode encoding, the controller state enum and the limb-count function.
package mp_pkg;

  // Operation request encoding on the mode port; reserved behaves as ADD.
  typedef enum logic [1:0] {
    MP_ADD  = 2'b00,
    MP_SUB  = 2'b01,
    MP_CSUB = 2'b10,
    MP_RSVD = 2'b11
  } mp_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } mp_state_e;

  // Number of LIMB-bit slices needed to cover a WIDTH-bit operand.
  function automatic int nlimbs(input int width, input int limb);
    return (width + limb - 1) / limb;
  endfunction

endpackage

// File: rtl/mp_limb_adder.sv
// rtl/mp_limb_adder.sv - combinational LIMB-bit adder with carry in and carry out
// Ports:
//   x_i, y_i  LIMB-bit addends
//   cin_i     carry in
//   sum_o     LIMB-bit sum
//   cout_o    carry out
module mp_limb_adder #(
  parameter int LIMB = 172
) (
  input  logic [LIMB-1:0] x_i,
  input  logic [LIMB-1:0] y_i,
  input  logic            cin_i,
  output logic [LIMB-1:0] sum_o,
  output logic            cout_o
);

  assign {cout_o, sum_o} = {1'b0, x_i} + {1'b0, y_i} + {{LIMB{1'b0}}, cin_i};

endmodule

// File: rtl/mp_addsub_pipe.sv
// rtl/mp_addsub_pipe.sv - multi-cycle multi-precision add / sub / conditional-subtract
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   start          operation request, sampled only in IDLE
//   mode           00 ADD, 01 SUB, 10 CSUB, 11 treated as ADD
//   in_a, in_b     unsigned WIDTH-bit operands, sampled with start
//   result         {carry / no-borrow, WIDTH-bit value}, held until next completion
//   ge             a >= b for SUB/CSUB, 0 for ADD
//   busy           high while an operation is in flight
//   done           one-cycle completion pulse
module mp_addsub_pipe
  import mp_pkg::*;
#(
  parameter int WIDTH = 1027,
  parameter int LIMB  = 172
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             ge,
  output logic             busy,
  output logic             done
);

  localparam int NLIMBS = nlimbs(WIDTH, LIMB);
  localparam int PADW   = NLIMBS * LIMB;
  localparam int CW     = $clog2(NLIMBS + 1);

  mp_state_e        state_q, state_d;
  mp_mode_e         mode_q, mode_d;
  logic [PADW-1:0]  a_q, a_d;
  logic [PADW-1:0]  b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acopy_q, acopy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             ge_q, ge_d;
  logic             done_q, done_d;

  logic             load, step, fin, last_limb;
  logic [LIMB-1:0]  limb_sum;
  logic             limb_cout;
  logic             add_cout;
  mp_mode_e         mode_in;

  mp_limb_adder #(.LIMB(LIMB)) u_limb_adder (
    .x_i    (a_q[LIMB-1:0]),
    .y_i    (b_q[LIMB-1:0]),
    .cin_i  (carry_q),
    .sum_o  (limb_sum),
    .cout_o (limb_cout)
  );

  // With padding, the ADD carry lands in bit WIDTH of the padded sum and the
  // final carry register is always 0; without padding it is the carry register.
  generate
    if (PADW > WIDTH) begin : g_pad_cout
      assign add_cout = a_q[WIDTH];
    end else begin : g_nopad_cout
      assign add_cout = carry_q;
    end
  endgenerate

  assign last_limb = (cnt_q == CW'(NLIMBS - 1));
  assign mode_in   = (mp_mode_e'(mode) == MP_RSVD) ? MP_ADD : mp_mode_e'(mode);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_limb) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs / datapath strobes
  always_comb begin
    load = (state_q == IDLE) && start;
    step = (state_q == RUN);
    fin  = (state_q == FINISH);
    busy = (state_q != IDLE);
  end

  always_comb begin
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    acopy_d  = acopy_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ge_d     = ge_q;
    done_d   = fin;

    if (load) begin
      mode_d  = mode_in;
      a_d     = PADW'(in_a);
      acopy_d = in_a;
      cnt_d   = '0;
      // Subtraction is a + ~b + 1; inverting the zero-extended b also fills
      // the pad bits with ones so the borrow ripples through them.
      if (mode_in == MP_ADD) begin
        b_d     = PADW'(in_b);
        carry_d = 1'b0;
      end else begin
        b_d     = ~PADW'(in_b);
        carry_d = 1'b1;
      end
    end

    if (step) begin
      // Low limb is consumed; its sum re-enters at the top so that after
      // NLIMBS steps a_q holds the complete padded result in place.
      a_d     = PADW'({limb_sum, a_q} >> LIMB);
      b_d     = b_q >> LIMB;
      carry_d = limb_cout;
      cnt_d   = cnt_q + CW'(1);
    end

    if (fin) begin
      case (mode_q)
        MP_SUB: begin
          result_d = {carry_q, a_q[WIDTH-1:0]};
          ge_d     = carry_q;
        end
        MP_CSUB: begin
          result_d = carry_q ? {1'b0, a_q[WIDTH-1:0]} : {1'b0, acopy_q};
          ge_d     = carry_q;
        end
        default: begin
          result_d = {add_cout, a_q[WIDTH-1:0]};
          ge_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q   <= MP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      acopy_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ge_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      acopy_q  <= acopy_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ge_q     <= ge_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign ge     = ge_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mp_addsub_pipe.sv
// tb/tb_mp_addsub_pipe.sv - self-checking bench for mp_addsub_pipe over four width/limb configurations
module tb_mp_addsub_pipe;

  typedef logic [1027:0] wide_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   start = '0;
  logic [1:0]   mode = '0;
  logic [1026:0] in_a = '0;
  logic [1026:0] in_b = '0;

  logic [1027:0] res0;
  logic [64:0]   res1;
  logic [67:0]   res2;
  logic [32:0]   res3;
  logic [3:0]    ge, busy, done;

  int errors = 0;
  int checks = 0;

  int cfg_w [4] = '{1027, 64, 67, 32};
  int cfg_l [4] = '{172, 16, 16, 32};

  always #5 clk = ~clk;

  mp_addsub_pipe #(.WIDTH(1027), .LIMB(172)) u0 (
    .clk(clk), .reset(rst), .start(start[0]), .mode(mode),
    .in_a(in_a), .in_b(in_b),
    .result(res0), .ge(ge[0]), .busy(busy[0]), .done(done[0]));

  mp_addsub_pipe #(.WIDTH(64), .LIMB(16)) u1 (
    .clk(clk), .reset(rst), .start(start[1]), .mode(mode),
    .in_a(in_a[63:0]), .in_b(in_b[63:0]),
    .result(res1), .ge(ge[1]), .busy(busy[1]), .done(done[1]));

  mp_addsub_pipe #(.WIDTH(67), .LIMB(16)) u2 (
    .clk(clk), .reset(rst), .start(start[2]), .mode(mode),
    .in_a(in_a[66:0]), .in_b(in_b[66:0]),
    .result(res2), .ge(ge[2]), .busy(busy[2]), .done(done[2]));

  mp_addsub_pipe #(.WIDTH(32), .LIMB(32)) u3 (
    .clk(clk), .reset(rst), .start(start[3]), .mode(mode),
    .in_a(in_a[31:0]), .in_b(in_b[31:0]),
    .result(res3), .ge(ge[3]), .busy(busy[3]), .done(done[3]));

  function automatic wide_t get_res(int k);
    case (k)
      0:       return res0;
      1:       return wide_t'(res1);
      2:       return wide_t'(res2);
      default: return wide_t'(res3);
    endcase
  endfunction

  function automatic wide_t rand_wide();
    wide_t r = '0;
    for (int i = 0; i < 33; i++) r = {r[995:0], 32'($urandom)};
    return r;
  endfunction

  // Reference: plain unsigned arithmetic on w-bit operands.
  function automatic void model(input int w, input logic [1:0] md, input wide_t a, input wide_t b,
                                output wide_t r, output logic g);
    logic [1039:0] one, m, x, y, t;
    one = 1040'd1;
    m   = (one << w) - one;
    x   = {12'b0, a} & m;
    y   = {12'b0, b} & m;
    g   = 1'b0;
    case (md)
      2'b01: begin
        g = (x >= y);
        t = ((x - y) & m) | (g ? (one << w) : '0);
      end
      2'b10: begin
        g = (x >= y);
        t = g ? (x - y) : x;
      end
      default: t = x + y;
    endcase
    r = t[1027:0];
  endfunction

  task automatic check(input string tag, input wide_t obs, input wide_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h..%h required=%h..%h", tag,
             obs[1027:996], obs[127:0], exp[1027:996], exp[127:0]);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge,
  // with the operand buses already scrambled.
  task automatic start_op(input int k, input logic [1:0] md, input wide_t a, input wide_t b);
    wide_t ra, rb;
    in_a     = a[1026:0];
    in_b     = b[1026:0];
    mode     = md;
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    ra   = rand_wide();
    rb   = rand_wide();
    in_a = ra[1026:0];
    in_b = rb[1026:0];
    mode = 2'($urandom);
  endtask

  task automatic wait_done(input int k, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!done[k] && lat < 40) begin
      if (busy[k]) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input int k, input logic [1:0] md, input wide_t a, input wide_t b,
                       input wide_t exp_r, input logic exp_g, input string tag, output int bc);
    int lat;
    int n;
    n = (cfg_w[k] + cfg_l[k] - 1) / cfg_l[k];
    start_op(k, md, a, b);
    wait_done(k, lat, bc);
    check({tag, "_lat"}, wide_t'(lat), wide_t'(n + 1));
    check({tag, "_res"}, get_res(k), exp_r);
    check({tag, "_ge"}, wide_t'(ge[k]), wide_t'(exp_g));
    @(negedge clk);
    check({tag, "_done1"}, wide_t'(done[k]), '0);
  endtask

  wide_t ones_w;
  wide_t top_bit;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    wide_t a, b, r, a1, b1, a3, b3;
    logic  g;
    int    bc, lat, dp, sel;

    ones_w  = {1'b0, {1027{1'b1}}};
    top_bit = wide_t'(1) << 1027;

    // Reset state
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_res0", res0, '0);
    check("rst_flags", wide_t'({busy, done, ge}), '0);
    rst = 1'b0;
    @(negedge clk);

    // T1: ADD carry-out, latency and busy duration
    do_op(0, 2'b00, ones_w, wide_t'(1), top_bit, 1'b0, "t1_add", bc);
    check("t1_busy_cycles", wide_t'(bc), wide_t'(7));

    // T2: SUB with borrow, and a == b
    do_op(0, 2'b01, wide_t'(5), wide_t'(7), ones_w - wide_t'(1), 1'b0, "t2_sub_5_7", bc);
    do_op(0, 2'b01, wide_t'(7), wide_t'(7), top_bit, 1'b1, "t2_sub_7_7", bc);

    // T3: CSUB both directions; operands are scrambled after start inside start_op
    do_op(0, 2'b10, wide_t'(100), wide_t'(30), wide_t'(70), 1'b1, "t3_csub_ge", bc);
    do_op(0, 2'b10, wide_t'(30), wide_t'(100), wide_t'(30), 1'b0, "t3_csub_lt", bc);

    // T4: start while busy is ignored; start in the done cycle is accepted
    a1 = rand_wide() & ones_w;
    b1 = rand_wide() & ones_w;
    start_op(0, 2'b00, a1, b1);
    repeat (2) @(negedge clk);
    a = rand_wide();
    b = rand_wide();
    in_a = a[1026:0];
    in_b = b[1026:0];
    mode = 2'b01;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, lat, bc);
    check("t4_ignored_lat", wide_t'(lat), wide_t'(4));
    check("t4_first_res", res0, a1 + b1);
    a3 = rand_wide() & ones_w;
    b3 = rand_wide() & ones_w;
    start_op(0, 2'b01, a3, b3);
    check("t4_hold_res", res0, a1 + b1);
    wait_done(0, lat, bc);
    model(1027, 2'b01, a3, b3, r, g);
    check("t4_b2b_lat", wide_t'(lat), wide_t'(7));
    check("t4_b2b_res", res0, r);
    check("t4_b2b_ge", wide_t'(ge[0]), wide_t'(g));
    @(negedge clk);
    check("t4_done1", wide_t'(done[0]), '0);

    // T5: asynchronous reset mid-RUN
    start_op(0, 2'b01, wide_t'(9), wide_t'(4));
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_res", res0, '0);
    check("t5_rst_flags", wide_t'({busy[0], done[0], ge[0]}), '0);
    dp = 0;
    repeat (3) begin
      @(negedge clk);
      if (done[0]) dp++;
    end
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done[0]) dp++;
    end
    check("t5_no_done", wide_t'(dp), '0);
    do_op(0, 2'b00, wide_t'(1), wide_t'(2), wide_t'(3), 1'b0, "t5_add_after", bc);

    // T6: random sweep on the small configurations, all four mode codes
    for (int k = 1; k < 4; k++) begin
      for (int md = 0; md < 4; md++) begin
        for (int i = 0; i < 150; i++) begin
          a   = rand_wide();
          b   = rand_wide();
          sel = int'($urandom_range(0, 7));
          if (sel == 0) b = a;
          else if (sel == 1) b = '0;
          else if (sel == 2) b = wide_t'(b[15:0]);
          model(cfg_w[k], 2'(md), a, b, r, g);
          do_op(k, 2'(md), a, b, r, g, $sformatf("rnd_w%0d_m%0d_%0d", cfg_w[k], md, i), bc);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
